// File: rtl/wb_gpio_pkg.sv
// -----------------------------------------------------------------------------
// wb_gpio_pkg
// Shared definitions for the Wishbone GPIO slave: register word addresses,
// the bus address type and the legal ranges of the block parameters.
// No ports (package).
// -----------------------------------------------------------------------------
package wb_gpio_pkg;

   typedef logic [2:0] adr_t;

   localparam adr_t ADR_OUT    = 3'd0;
   localparam adr_t ADR_OE     = 3'd1;
   localparam adr_t ADR_IN     = 3'd2;
   localparam adr_t ADR_MASK   = 3'd3;
   localparam adr_t ADR_STATUS = 3'd4;
   localparam adr_t ADR_EDGE   = 3'd5;

   localparam int WIDTH_MIN = 1;
   localparam int WIDTH_MAX = 32;
   localparam int WAIT_MAX  = 15;
   localparam int SYNC_MIN  = 2;
   localparam int SYNC_MAX  = 4;

endpackage

// File: rtl/wb_gpio_if.sv
// -----------------------------------------------------------------------------
// wb_gpio_if
// Pipelined Wishbone bus bundle between the J1 data-bus master and the GPIO.
// Handshake: an access is valid while wb_cyc & wb_stb; it is accepted on a
// rising clk edge where valid & ~wb_stall; wb_ack is high for exactly one
// cycle, the cycle after each accept, and read data in wb_dat_o is valid
// while wb_ack is high.
//   master drives : wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_i
//   slave drives  : wb_dat_o, wb_ack, wb_stall
// -----------------------------------------------------------------------------
interface wb_gpio_if
   import wb_gpio_pkg::*;
#(
   parameter int WIDTH = 16
) ();

   logic             wb_cyc;
   logic             wb_stb;
   logic             wb_we;
   adr_t             wb_adr;
   logic [WIDTH-1:0] wb_dat_i;
   logic [WIDTH-1:0] wb_dat_o;
   logic             wb_ack;
   logic             wb_stall;

   modport master (
      output wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_i,
      input  wb_dat_o, wb_ack, wb_stall
   );

   modport slave (
      input  wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_i,
      output wb_dat_o, wb_ack, wb_stall
   );

endinterface

// File: rtl/gpio_edge_sync.sv
// -----------------------------------------------------------------------------
// gpio_edge_sync
// Synchronises asynchronous pad inputs and produces per-bit edge events.
//   clk, rst_n : clock, asynchronous active-low reset
//   din_i      : raw pad inputs
//   edge_i     : per-bit edge select (0 = rising, 1 = falling)
//   sync_o     : synchronised inputs (last chain stage)
//   evt_o      : one-cycle edge event per bit, suppressed until primed
// -----------------------------------------------------------------------------
module gpio_edge_sync #(
   parameter int WIDTH       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din_i,
   input  logic [WIDTH-1:0] edge_i,
   output logic [WIDTH-1:0] sync_o,
   output logic [WIDTH-1:0] evt_o
);

   localparam int PCNT_W = $clog2(SYNC_STAGES + 1);

   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
   logic [WIDTH-1:0]                  prev_q;
   logic [PCNT_W-1:0]                 pcnt_q;
   logic                              primed_q;
   logic [WIDTH-1:0]                  rise;
   logic [WIDTH-1:0]                  fall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q   <= '0;
         prev_q   <= '0;
         pcnt_q   <= '0;
         primed_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din_i};
         prev_q <= sync_q[SYNC_STAGES-1];
         // primed rises on edge SYNC_STAGES+1 after reset release: by then
         // prev has caught up with an input that was already high at reset,
         // so that level never shows up as a rising edge.
         if (pcnt_q != PCNT_W'(SYNC_STAGES)) begin
            pcnt_q <= pcnt_q + 1'b1;
         end else begin
            primed_q <= 1'b1;
         end
      end
   end

   assign sync_o = sync_q[SYNC_STAGES-1];
   assign rise   = sync_o & ~prev_q;
   assign fall   = ~sync_o & prev_q;
   assign evt_o  = primed_q ? ((edge_i & fall) | (~edge_i & rise)) : '0;

endmodule

// File: rtl/wb_gpio.sv
// -----------------------------------------------------------------------------
// wb_gpio
// Wishbone GPIO slave with output data/enable registers, synchronised inputs,
// per-bit edge interrupts (MASK, W1C STATUS, EDGE select) and wait states.
//   clk, rst_n : clock, asynchronous active-low reset
//   wb         : pipelined Wishbone slave port (wb_gpio_if.slave)
//   io_in      : asynchronous pad inputs
//   io_out     : output data register
//   io_oe      : per-bit output enable (1 = drive)
//   irq        : registered level interrupt, |(STATUS & MASK)
// -----------------------------------------------------------------------------
module wb_gpio
   import wb_gpio_pkg::*;
#(
   parameter int WIDTH       = 16,
   parameter int WAITCYCLES  = 0,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   wb_gpio_if.slave         wb,
   input  logic [WIDTH-1:0] io_in,
   output logic [WIDTH-1:0] io_out,
   output logic [WIDTH-1:0] io_oe,
   output logic             irq
);

   if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
      $error("wb_gpio: WIDTH out of range");
   end
   if (WAITCYCLES < 0 || WAITCYCLES > WAIT_MAX) begin : g_bad_wait
      $error("wb_gpio: WAITCYCLES out of range");
   end
   if (SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX) begin : g_bad_sync
      $error("wb_gpio: SYNC_STAGES out of range");
   end

   localparam logic [3:0] WAIT_LIM = 4'(WAITCYCLES);

   logic             valid, accept, wr;
   logic [3:0]       cnt_q, cnt_d;
   logic             ack_q;
   logic [WIDTH-1:0] dat_q, dat_d, rdata;
   logic [WIDTH-1:0] out_q, out_d, oe_q, oe_d, mask_q, mask_d;
   logic [WIDTH-1:0] status_q, status_d, edge_q, edge_d, w1c;
   logic             irq_q, irq_d;
   logic [WIDTH-1:0] sync, evt;

   gpio_edge_sync #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_edge_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .din_i  (io_in),
      .edge_i (edge_q),
      .sync_o (sync),
      .evt_o  (evt)
   );

   assign valid       = wb.wb_cyc & wb.wb_stb;
   assign wb.wb_stall = valid & (cnt_q != WAIT_LIM);
   assign accept      = valid & ~wb.wb_stall;
   assign wr          = accept & wb.wb_we;

   always_comb begin
      rdata = '0;
      case (wb.wb_adr)
         ADR_OUT:    rdata = out_q;
         ADR_OE:     rdata = oe_q;
         ADR_IN:     rdata = sync;
         ADR_MASK:   rdata = mask_q;
         ADR_STATUS: rdata = status_q;
         ADR_EDGE:   rdata = edge_q;
         default:    rdata = '0;
      endcase
   end

   always_comb begin
      cnt_d  = cnt_q;
      dat_d  = dat_q;
      out_d  = out_q;
      oe_d   = oe_q;
      mask_d = mask_q;
      edge_d = edge_q;
      w1c    = '0;
      // Dropping valid mid-stall restarts the wait count.
      if (!valid || accept) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 4'd1;
      end
      if (accept && !wb.wb_we) begin
         dat_d = rdata;
      end
      if (wr) begin
         case (wb.wb_adr)
            ADR_OUT:    out_d  = wb.wb_dat_i;
            ADR_OE:     oe_d   = wb.wb_dat_i;
            ADR_MASK:   mask_d = wb.wb_dat_i;
            ADR_STATUS: w1c    = wb.wb_dat_i;
            ADR_EDGE:   edge_d = wb.wb_dat_i;
            default:    ;
         endcase
      end
      // OR-ing evt last lets a new event win over a same-cycle clear.
      status_d = (status_q & ~w1c) | evt;
      irq_d    = |(status_d & mask_d);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         ack_q    <= 1'b0;
         dat_q    <= '0;
         out_q    <= '0;
         oe_q     <= '0;
         mask_q   <= '0;
         status_q <= '0;
         edge_q   <= '0;
         irq_q    <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         ack_q    <= accept;
         dat_q    <= dat_d;
         out_q    <= out_d;
         oe_q     <= oe_d;
         mask_q   <= mask_d;
         status_q <= status_d;
         edge_q   <= edge_d;
         irq_q    <= irq_d;
      end
   end

   assign wb.wb_ack   = ack_q;
   assign wb.wb_dat_o = dat_q;
   assign io_out      = out_q;
   assign io_oe       = oe_q;
   assign irq         = irq_q;

endmodule

// File: tb/tb_wb_gpio.sv
// -----------------------------------------------------------------------------
// tb_wb_gpio
// Self-checking bench for wb_gpio: u0 has no wait states, u3 has three.
// -----------------------------------------------------------------------------
module tb_wb_gpio;
   import wb_gpio_pkg::*;

   localparam int SYNC = 2;

   logic        clk;
   logic        rst_n;
   logic [15:0] io_in0, io_out0, io_oe0;
   logic [15:0] io_in3, io_out3, io_oe3;
   logic        irq0, irq3;

   int checks = 0;
   int errors = 0;

   wb_gpio_if #(.WIDTH(16)) bus0 ();
   wb_gpio_if #(.WIDTH(16)) bus3 ();

   wb_gpio #(.WIDTH(16), .WAITCYCLES(0), .SYNC_STAGES(SYNC)) u0 (
      .clk(clk), .rst_n(rst_n), .wb(bus0.slave),
      .io_in(io_in0), .io_out(io_out0), .io_oe(io_oe0), .irq(irq0)
   );

   wb_gpio #(.WIDTH(16), .WAITCYCLES(3), .SYNC_STAGES(SYNC)) u3 (
      .clk(clk), .rst_n(rst_n), .wb(bus3.slave),
      .io_in(io_in3), .io_out(io_out3), .io_oe(io_oe3), .irq(irq3)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Single access on u0; called #1 after a rising edge, returns in the ack cycle.
   task automatic acc0(input logic we, input adr_t adr, input logic [15:0] wdat,
                       output logic [15:0] rdat);
      bus0.wb_cyc   = 1'b1;
      bus0.wb_stb   = 1'b1;
      bus0.wb_we    = we;
      bus0.wb_adr   = adr;
      bus0.wb_dat_i = wdat;
      #1;
      chk("u0_no_stall", {31'd0, bus0.wb_stall}, 32'd0);
      @(posedge clk);
      #1;
      bus0.wb_cyc = 1'b0;
      bus0.wb_stb = 1'b0;
      bus0.wb_we  = 1'b0;
      chk("u0_ack", {31'd0, bus0.wb_ack}, 32'd1);
      rdat = bus0.wb_dat_o;
   endtask

   // Read on u3; counts stall cycles and reports the cycle index of the ack
   // (cycle 1 = the cycle stb rises, 0 = timed out).
   task automatic rd3(input adr_t adr, output int nstall, output int ack_k,
                      output logic [15:0] rdat);
      bus3.wb_cyc = 1'b1;
      bus3.wb_stb = 1'b1;
      bus3.wb_we  = 1'b0;
      bus3.wb_adr = adr;
      nstall = 0;
      ack_k  = 0;
      rdat   = '0;
      #1;
      for (int k = 1; k <= 20; k++) begin
         if (bus3.wb_stall) begin
            nstall++;
            tick();
         end else begin
            tick();
            bus3.wb_cyc = 1'b0;
            bus3.wb_stb = 1'b0;
            ack_k = bus3.wb_ack ? k + 1 : -1;
            rdat  = bus3.wb_dat_o;
            break;
         end
      end
      bus3.wb_cyc = 1'b0;
      bus3.wb_stb = 1'b0;
   endtask

   typedef struct {
      logic        we;
      adr_t        adr;
      logic [15:0] wdat;
      logic        chk_rd;
      logic [15:0] exp_rd;
      logic [15:0] exp_out;
      logic [15:0] exp_oe;
   } vec_t;

   typedef struct {
      logic        we;
      adr_t        adr;
      logic [15:0] wdat;
      logic        chk_rd;
      logic [15:0] exp_rd;
   } bst_t;

   vec_t        vecs [13];
   bst_t        bst  [4];
   logic [15:0] rd;
   int          ns, ak;
   logic        seen;

   initial begin
      vecs[0]  = '{1'b1, ADR_OE,     16'h00FF, 1'b0, 16'h0000, 16'h0000, 16'h00FF};
      vecs[1]  = '{1'b1, ADR_OUT,    16'hA5A5, 1'b0, 16'h0000, 16'hA5A5, 16'h00FF};
      vecs[2]  = '{1'b0, ADR_OE,     16'h0000, 1'b1, 16'h00FF, 16'hA5A5, 16'h00FF};
      vecs[3]  = '{1'b0, ADR_OUT,    16'h0000, 1'b1, 16'hA5A5, 16'hA5A5, 16'h00FF};
      vecs[4]  = '{1'b1, ADR_MASK,   16'h0001, 1'b0, 16'h0000, 16'hA5A5, 16'h00FF};
      vecs[5]  = '{1'b0, ADR_MASK,   16'h0000, 1'b1, 16'h0001, 16'hA5A5, 16'h00FF};
      vecs[6]  = '{1'b1, ADR_EDGE,   16'h0000, 1'b0, 16'h0000, 16'hA5A5, 16'h00FF};
      vecs[7]  = '{1'b0, ADR_EDGE,   16'h0000, 1'b1, 16'h0000, 16'hA5A5, 16'h00FF};
      vecs[8]  = '{1'b1, 3'd7,       16'hFFFF, 1'b0, 16'h0000, 16'hA5A5, 16'h00FF};
      vecs[9]  = '{1'b0, 3'd7,       16'h0000, 1'b1, 16'h0000, 16'hA5A5, 16'h00FF};
      vecs[10] = '{1'b0, 3'd6,       16'h0000, 1'b1, 16'h0000, 16'hA5A5, 16'h00FF};
      vecs[11] = '{1'b0, ADR_STATUS, 16'h0000, 1'b1, 16'h0000, 16'hA5A5, 16'h00FF};
      vecs[12] = '{1'b0, ADR_IN,     16'h0000, 1'b1, 16'h0000, 16'hA5A5, 16'h00FF};

      bst[0] = '{1'b1, ADR_OUT, 16'h5A3C, 1'b0, 16'h0000};
      bst[1] = '{1'b0, ADR_OUT, 16'h0000, 1'b1, 16'h5A3C};
      bst[2] = '{1'b0, 3'd7,    16'h0000, 1'b1, 16'h0000};
      bst[3] = '{1'b1, 3'd6,    16'hFFFF, 1'b0, 16'h0000};

      rst_n = 1'b0;
      bus0.wb_cyc = 1'b0; bus0.wb_stb = 1'b0; bus0.wb_we = 1'b0;
      bus0.wb_adr = '0;   bus0.wb_dat_i = '0;
      bus3.wb_cyc = 1'b0; bus3.wb_stb = 1'b0; bus3.wb_we = 1'b0;
      bus3.wb_adr = '0;   bus3.wb_dat_i = '0;
      io_in0 = 16'h0000;
      io_in3 = 16'h1234;

      // reset state
      #23;
      chk("rst_ack",    {31'd0, bus0.wb_ack}, 32'd0);
      chk("rst_dat_o",  {16'd0, bus0.wb_dat_o}, 32'd0);
      chk("rst_io_out", {16'd0, io_out0}, 32'd0);
      chk("rst_io_oe",  {16'd0, io_oe0}, 32'd0);
      chk("rst_irq",    {31'd0, irq0}, 32'd0);
      chk("rst_u3_out", {16'd0, io_out3 | io_oe3}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) tick();

      // register access vectors on u0
      for (int i = 0; i < 13; i++) begin
         acc0(vecs[i].we, vecs[i].adr, vecs[i].wdat, rd);
         if (vecs[i].chk_rd) chk($sformatf("vec%0d_rd", i), {16'd0, rd}, {16'd0, vecs[i].exp_rd});
         chk($sformatf("vec%0d_io_out", i), {16'd0, io_out0}, {16'd0, vecs[i].exp_out});
         chk($sformatf("vec%0d_io_oe", i),  {16'd0, io_oe0},  {16'd0, vecs[i].exp_oe});
      end

      // wait states on u3
      rd3(ADR_IN, ns, ak, rd);
      chk("t2_stall_cycles", ns, 32'd3);
      chk("t2_ack_cycle", ak, 32'd5);
      chk("t2_rdata", {16'd0, rd}, 32'h1234);
      chk("t2_u3_irq", {31'd0, irq3}, 32'd0);
      tick();
      chk("t2_ack_single", {31'd0, bus3.wb_ack}, 32'd0);

      // stb dropped mid-stall restarts the wait count
      bus3.wb_cyc = 1'b1; bus3.wb_stb = 1'b1; bus3.wb_adr = ADR_IN;
      tick();
      tick();
      chk("t2b_stalling", {31'd0, bus3.wb_stall}, 32'd1);
      bus3.wb_cyc = 1'b0; bus3.wb_stb = 1'b0;
      tick();
      rd3(ADR_IN, ns, ak, rd);
      chk("t2b_stall_cycles", ns, 32'd3);
      chk("t2b_ack_cycle", ak, 32'd5);

      // rising edge interrupt (MASK=1, EDGE=0 already programmed)
      io_in0[0] = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < SYNC + 2 && !seen; i++) begin
         tick();
         if (irq0) seen = 1'b1;
      end
      chk("t3_irq_rise", {31'd0, seen}, 32'd1);
      acc0(1'b0, ADR_STATUS, 16'h0, rd);
      chk("t3_status", {16'd0, rd}, 32'h0001);
      acc0(1'b1, ADR_STATUS, 16'h0001, rd);
      tick();
      chk("t3_irq_drop", {31'd0, irq0}, 32'd0);
      acc0(1'b0, ADR_STATUS, 16'h0, rd);
      chk("t3_status_clr", {16'd0, rd}, 32'h0000);

      // falling edge, masked, then unmasked
      acc0(1'b1, ADR_EDGE, 16'h0008, rd);
      acc0(1'b1, ADR_MASK, 16'h0000, rd);
      io_in0[3] = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      io_in0[3] = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      acc0(1'b0, ADR_STATUS, 16'h0, rd);
      chk("t4_status", {16'd0, rd}, 32'h0008);
      chk("t4_irq_masked", {31'd0, irq0}, 32'd0);
      acc0(1'b1, ADR_MASK, 16'h0008, rd);
      tick();
      chk("t4_irq_unmasked", {31'd0, irq0}, 32'd1);
      acc0(1'b1, ADR_STATUS, 16'hFFFF, rd);
      acc0(1'b1, ADR_MASK, 16'h0000, rd);
      acc0(1'b0, ADR_STATUS, 16'h0, rd);
      chk("t4_status_clr", {16'd0, rd}, 32'h0000);

      // set wins over a same-cycle W1C
      io_in0[0] = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      io_in0[0] = 1'b1;
      tick();
      tick();
      acc0(1'b1, ADR_STATUS, 16'h0001, rd);
      acc0(1'b0, ADR_STATUS, 16'h0, rd);
      chk("t5_set_wins", {16'd0, rd}, 32'h0001);

      // reset during an access, with inputs held high through reset
      io_in0 = 16'hFFFF;
      bus0.wb_cyc = 1'b1; bus0.wb_stb = 1'b1; bus0.wb_we = 1'b1;
      bus0.wb_adr = ADR_OUT; bus0.wb_dat_i = 16'h1111;
      tick();
      chk("t5_ack_before_rst", {31'd0, bus0.wb_ack}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("t5_ack_dropped", {31'd0, bus0.wb_ack}, 32'd0);
      chk("t5_io_out_rst", {16'd0, io_out0}, 32'd0);
      bus0.wb_cyc = 1'b0; bus0.wb_stb = 1'b0; bus0.wb_we = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      acc0(1'b0, ADR_STATUS, 16'h0, rd);
      chk("t5_no_reset_edge", {16'd0, rd}, 32'h0000);
      chk("t5_irq_quiet", {31'd0, irq0}, 32'd0);
      acc0(1'b0, ADR_IN, 16'h0, rd);
      chk("t5_in_high", {16'd0, rd}, 32'hFFFF);

      // pipelined burst with stb held
      bus0.wb_cyc = 1'b1;
      bus0.wb_stb = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus0.wb_we   = bst[i].we;
         bus0.wb_adr  = bst[i].adr;
         bus0.wb_dat_i = bst[i].wdat;
         #1;
         chk($sformatf("t6_stall%0d", i), {31'd0, bus0.wb_stall}, 32'd0);
         if (i > 0) begin
            chk($sformatf("t6_ack%0d", i - 1), {31'd0, bus0.wb_ack}, 32'd1);
            if (bst[i-1].chk_rd)
               chk($sformatf("t6_rd%0d", i - 1), {16'd0, bus0.wb_dat_o}, {16'd0, bst[i-1].exp_rd});
         end
         tick();
      end
      bus0.wb_cyc = 1'b0;
      bus0.wb_stb = 1'b0;
      bus0.wb_we  = 1'b0;
      chk("t6_ack3", {31'd0, bus0.wb_ack}, 32'd1);
      chk("t6_dat_hold", {16'd0, bus0.wb_dat_o}, 32'h0000);
      tick();
      chk("t6_ack_end", {31'd0, bus0.wb_ack}, 32'd0);
      chk("t6_io_out", {16'd0, io_out0}, 32'h5A3C);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
